// File: rtl/pipeline_stall_sequencer.sv
// Central stall/flush sequencer for the 5-stage MIPS pipeline. It merges the
// load-use, branch-flush and data-memory-wait requests into one set of enables.
module pipeline_stall_sequencer #(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             EX_MemoryRead,
  input  logic [4:0]       EX_rt,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic [5:0]       ID_Op,
  input  logic             BranchTaken,
  input  logic             MEM_Access,
  input  logic             MEM_Ready,
  input  logic             ErrAck,
  output logic             PC_WriteEnable,
  output logic             IFID_WriteEnable,
  output logic             IFID_Flush,
  output logic             IDEX_Bubble,
  output logic             Pipe_Hold,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'd0,
    MODE_FLUSH  = 2'd1,
    MODE_STALL  = 2'd2,
    MODE_FREEZE = 2'd3
  } mode_t;

  // ID opcodes whose rt field is a destination, so it cannot create a load-use hazard
  localparam logic [5:0]        OP_LW       = 6'b100011;
  localparam logic [5:0]        OP_XORI     = 6'b001110;
  localparam logic [WAIT_W-1:0] LP_MAX_WAIT = WAIT_W'(MAX_WAIT);

  state_t            r_state;
  state_t            w_state_next;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_cnt_next;
  logic [CNT_W-1:0]  r_stall_cnt;

  mode_t             w_mode;
  mode_t             w_release_mode;
  logic              w_rt_is_dest;
  logic              w_load_use;
  logic              w_pc_we;
  logic              w_ifid_we;
  logic              w_ifid_flush;
  logic              w_idex_bubble;
  logic              w_pipe_hold;

  assign w_rt_is_dest = (ID_Op == OP_LW) | (ID_Op == OP_XORI);
  assign w_load_use   = EX_MemoryRead & (EX_rt != 5'd0) &
                        ((EX_rt == ID_rs) | ((EX_rt == ID_rt) & ~w_rt_is_dest));

  // Mode used whenever memory is not holding the pipe: load-use beats branch flush
  assign w_release_mode = w_load_use  ? MODE_STALL :
                          BranchTaken ? MODE_FLUSH : MODE_NORMAL;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    w_mode          = w_release_mode;
    case (r_state)
      RUN: begin
        if (MEM_Access & ~MEM_Ready) begin
          w_mode          = MODE_FREEZE;
          w_state_next    = MEM_WAIT;
          w_wait_cnt_next = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (MEM_Ready) begin
          w_state_next    = RUN;
          w_wait_cnt_next = '0;
        end else begin
          w_mode = MODE_FREEZE;
          if (r_wait_cnt >= LP_MAX_WAIT) begin
            w_state_next = ERR;
          end else begin
            w_wait_cnt_next = r_wait_cnt + WAIT_W'(1);
          end
        end
      end
      ERR: begin
        // MEM_Ready is deliberately ignored; only an acknowledge leaves ERR
        w_mode = MODE_FREEZE;
        if (ErrAck) begin
          w_state_next    = RUN;
          w_wait_cnt_next = '0;
        end
      end
      default: begin
        w_mode          = MODE_FREEZE;
        w_state_next    = RUN;
        w_wait_cnt_next = '0;
      end
    endcase
  end

  always_comb begin
    w_pc_we       = 1'b1;
    w_ifid_we     = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b0;
    w_pipe_hold   = 1'b0;
    case (w_mode)
      MODE_FREEZE: begin
        w_pc_we     = 1'b0;
        w_ifid_we   = 1'b0;
        w_pipe_hold = 1'b1;
      end
      MODE_STALL: begin
        w_pc_we       = 1'b0;
        w_ifid_we     = 1'b0;
        w_idex_bubble = 1'b1;
      end
      MODE_FLUSH: begin
        w_ifid_flush = 1'b1;
      end
      default: begin
      end
    endcase
    // Reset holds the whole pipe immediately, without waiting for a clock
    if (!reset_n) begin
      w_pc_we       = 1'b0;
      w_ifid_we     = 1'b0;
      w_ifid_flush  = 1'b0;
      w_idex_bubble = 1'b0;
      w_pipe_hold   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
    end else if (!w_pc_we && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign PC_WriteEnable   = w_pc_we;
  assign IFID_WriteEnable = w_ifid_we;
  assign IFID_Flush       = w_ifid_flush;
  assign IDEX_Bubble      = w_idex_bubble;
  assign Pipe_Hold        = w_pipe_hold;
  assign MemTimeout       = reset_n & (r_state == ERR);
  assign StallCycles      = r_stall_cnt;

endmodule
